// File: rtl/ysyx_exu_muldiv_sched.sv
// Scheduler that shares one multiply/divide unit among reservation-station entries.
// Round-robin pick in IDLE, one-cycle start pulse to the unit, wait for the
// result, then one-cycle write-back to the granted entry. A flush while the unit
// is busy drains its pending result without writing it back. A bounded wait
// raises a sticky timeout error.
module ysyx_exu_muldiv_sched #(
    parameter int RS_SIZE = 4,
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [RS_SIZE-1:0]         req_valid,
    input  logic [RS_SIZE*XLEN-1:0]    req_a,
    input  logic [RS_SIZE*XLEN-1:0]    req_b,
    input  logic [RS_SIZE*5-1:0]       req_op,
    output logic                       mul_valid,
    output logic [XLEN-1:0]            mul_a,
    output logic [XLEN-1:0]            mul_b,
    output logic [4:0]                 mul_op,
    input  logic                       mul_out_valid,
    input  logic [XLEN-1:0]            mul_out_r,
    output logic                       done_valid,
    output logic [$clog2(RS_SIZE)-1:0] done_idx,
    output logic [XLEN-1:0]            done_result,
    output logic                       busy,
    output logic                       err_timeout
);

    localparam int IDXW = $clog2(RS_SIZE);
    localparam int CW   = $clog2(TIMEOUT + 1);

    localparam logic [IDXW-1:0] IDX_ONE   = IDXW'(1);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    // The timeout fires on the cycle whose increment makes the counter TIMEOUT-1.
    localparam logic [CW-1:0]   CNT_LIMIT = CW'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic [IDXW-1:0]   rr_ptr_r;
    logic [IDXW-1:0]   idx_r;
    logic [XLEN-1:0]   a_r;
    logic [XLEN-1:0]   b_r;
    logic [4:0]        op_r;
    logic [XLEN-1:0]   result_r;
    logic [CW-1:0]     cnt_r;
    logic              err_r;

    logic              grant_found_s;
    logic [IDXW-1:0]   grant_idx_s;
    logic [IDXW-1:0]   cand_s;
    logic [XLEN-1:0]   sel_a_s;
    logic [XLEN-1:0]   sel_b_s;
    logic [4:0]        sel_op_s;
    logic              grant_s;
    logic              capture_s;
    logic              timeout_s;
    logic              cnt_clr_s;
    logic              cnt_inc_s;
    logic              timeout_hit_s;

    // Round-robin search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = {IDXW{1'b0}};
        cand_s        = {IDXW{1'b0}};
        for (int k = 0; k < RS_SIZE; k++) begin
            cand_s = rr_ptr_r + IDXW'(k);
            if (!grant_found_s && req_valid[cand_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Operand/op select for the winning entry.
    always_comb begin
        sel_a_s  = {XLEN{1'b0}};
        sel_b_s  = {XLEN{1'b0}};
        sel_op_s = 5'd0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (grant_idx_s == IDXW'(i)) begin
                sel_a_s  = req_a[i*XLEN +: XLEN];
                sel_b_s  = req_b[i*XLEN +: XLEN];
                sel_op_s = req_op[i*5 +: 5];
            end else begin
                sel_op_s = sel_op_s;
            end
        end
    end

    assign timeout_hit_s = (cnt_r == CNT_LIMIT);

    // Next-state logic and datapath enables.
    always_comb begin
        state_nx_s = state_r;
        grant_s    = 1'b0;
        capture_s  = 1'b0;
        timeout_s  = 1'b0;
        cnt_clr_s  = 1'b0;
        cnt_inc_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_found_s && !flush) begin
                    grant_s    = 1'b1;
                    cnt_clr_s  = 1'b1;
                    state_nx_s = ST_ISSUE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ISSUE, ST_WAIT: begin
                cnt_inc_s = (state_r == ST_WAIT);
                if (mul_out_valid) begin
                    // A response coinciding with flush is simply dropped;
                    // the unit is already free so there is nothing to drain.
                    if (flush) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        capture_s  = 1'b1;
                        state_nx_s = ST_DONE;
                    end
                end else if ((state_r == ST_WAIT) && timeout_hit_s) begin
                    timeout_s  = 1'b1;
                    state_nx_s = ST_IDLE;
                end else if (flush) begin
                    state_nx_s = ST_DRAIN;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            ST_DRAIN: begin
                cnt_inc_s = 1'b1;
                if (mul_out_valid) begin
                    state_nx_s = ST_IDLE;
                end else if (timeout_hit_s) begin
                    timeout_s  = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Latched operands, result, round-robin pointer, wait counter and error flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_r <= {IDXW{1'b0}};
            idx_r    <= {IDXW{1'b0}};
            a_r      <= {XLEN{1'b0}};
            b_r      <= {XLEN{1'b0}};
            op_r     <= 5'd0;
            result_r <= {XLEN{1'b0}};
            cnt_r    <= {CW{1'b0}};
            err_r    <= 1'b0;
        end else begin
            if (grant_s) begin
                rr_ptr_r <= grant_idx_s + IDX_ONE;
                idx_r    <= grant_idx_s;
                a_r      <= sel_a_s;
                b_r      <= sel_b_s;
                op_r     <= sel_op_s;
            end
            if (capture_s) begin
                result_r <= mul_out_r;
            end
            if (cnt_clr_s) begin
                cnt_r <= {CW{1'b0}};
            end else if (cnt_inc_s) begin
                cnt_r <= cnt_r + CNT_ONE;
            end
            if (timeout_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign mul_valid   = (state_r == ST_ISSUE);
    assign mul_a       = a_r;
    assign mul_b       = b_r;
    assign mul_op      = op_r;
    // Flush kills the write-back in the same cycle it arrives.
    assign done_valid  = (state_r == ST_DONE) && !flush;
    assign done_idx    = idx_r;
    assign done_result = result_r;
    assign busy        = (state_r != ST_IDLE);
    assign err_timeout = err_r;

endmodule

// File: doc/ysyx_exu_muldiv_sched.md
YSYX_EXU_MULDIV_SCHED -- requirements
Module: ysyx_exu_muldiv_sched

Interface
REQ-001 SHALL have parameter RS_SIZE, default 4, number of reservation-station requesters (power of 2, >=2).
REQ-002 SHALL have parameter XLEN, default 32, operand/result width.
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum cycles to wait for a unit response.
REQ-004 SHALL have port clock  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush  in  1  pipeline flush, synchronous.
REQ-006 SHALL have port req_valid  in  RS_SIZE  entry i has operands ready and is an M-op awaiting a result.
REQ-007 SHALL have port req_a  in  RS_SIZE*XLEN  operand A of entry i, bits [i*XLEN +: XLEN].
REQ-008 SHALL have port req_b  in  RS_SIZE*XLEN  operand B of entry i, same packing.
REQ-009 SHALL have port req_op  in  RS_SIZE*5  ALU op of entry i, bits [i*5 +: 5].
REQ-010 SHALL have ports mul_valid out 1, mul_a out XLEN, mul_b out XLEN, mul_op out 5: start pulse and operands to the shared M-unit.
REQ-011 SHALL have ports mul_out_valid in 1, mul_out_r in XLEN: M-unit result strobe and data.
REQ-012 SHALL have ports done_valid out 1, done_idx out log2(RS_SIZE), done_result out XLEN: result return to entry done_idx.
REQ-013 SHALL have ports busy out 1 (state != IDLE) and err_timeout out 1 (sticky error).

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE, DRAIN.
REQ-015 IDLE: if any req_valid and no flush, SHALL latch grant index, operands, and op, and go to ISSUE next cycle.
REQ-016 Arbitration SHALL be round-robin: grant the lowest index >= rr_ptr with req_valid set, wrapping modulo RS_SIZE.
REQ-017 On grant, rr_ptr SHALL become (grant+1) mod RS_SIZE; rr_ptr SHALL NOT change otherwise.
REQ-018 req_* SHALL be sampled only in IDLE; changes in other states SHALL be ignored.
REQ-019 ISSUE: mul_valid SHALL be 1 for exactly this cycle, with mul_a/mul_b/mul_op from the latched values; next state is WAIT.
REQ-020 In ISSUE or WAIT, mul_out_valid=1 SHALL capture mul_out_r and go to DONE.
REQ-021 DONE: done_valid=1 for exactly one cycle, with the latched done_idx and captured done_result; next state is IDLE.
REQ-022 Latency SHALL be: request in IDLE at cycle t -> mul_valid at t+1; mul_out_valid at cycle w -> done_valid at w+1.
REQ-023 A wait counter SHALL clear on entry to ISSUE and increment each cycle in WAIT/DRAIN.
REQ-024 If the counter reaches TIMEOUT-1 without mul_out_valid, err_timeout SHALL set, the state SHALL go to IDLE, and no done_valid SHALL be issued.
REQ-025 flush in ISSUE or WAIT SHALL go to DRAIN, since the unit holds an operation.
REQ-026 DRAIN: mul_out_valid (or timeout) SHALL go to IDLE with the result discarded; done_valid SHALL stay 0.
REQ-027 flush in DONE SHALL suppress done_valid combinationally in that cycle and go to IDLE.
REQ-028 flush in IDLE SHALL block any grant that cycle.
REQ-029 mul_out_valid in IDLE or DONE SHALL be ignored.
REQ-030 mul_a, mul_b, mul_op, and done_result SHALL hold their latched values outside their strobe cycles.

Reset
REQ-031 reset SHALL force state IDLE, rr_ptr=0, counter=0, and err_timeout=0.
REQ-032 reset SHALL force mul_valid=0, done_valid=0, busy=0, done_idx=0, done_result=0, mul_a=0, mul_b=0, mul_op=0.
REQ-033 reset mid-operation (any state) SHALL abandon it; the first post-reset grant SHALL start from rr_ptr=0.
REQ-034 reset SHALL take priority over flush.

Verification
REQ-035 Single request: req_valid=0b0100, a=7, b=6, unit responds 3 cycles after mul_valid with 42 -> mul_valid at t+1, done_valid at t+5 with idx=2, result=42, rr_ptr=3.
REQ-036 Fairness: req_valid=0b1111 held, rr_ptr=0 -> grant order 0,1,2,3,0; each entry is granted once per 4 operations.
REQ-037 Wrap: rr_ptr=3, req_valid=0b0011 -> grant 0, then 1.
REQ-038 Flush in WAIT: flush at WAIT cycle 1, response 2 cycles later -> DRAIN, no done_valid, busy drops the cycle after the response, next grant proceeds normally.
REQ-039 Timeout: no mul_out_valid with TIMEOUT=8 -> err_timeout=1 eight cycles after ISSUE, state IDLE, err_timeout holds until reset.
REQ-040 Flush coincident with DONE -> done_valid=0 that cycle, and the state is IDLE next cycle.
